// File: rtl/wavegen_dds_core.sv
// DDS waveform generator: phase accumulator, per-mode shaping, amplitude scaling; WAVEGEN_SINE_LUT_EN selects sine for mode 3.
// Latency: wave_out is registered from the previous cycle's phase; wrap and wave_valid are one-cycle registered strobes.
// Backpressure: cfg_ready stays low while a committed-at-wrap config is pending; the source holds cfg_valid until accepted.
module wavegen_dds_core #(
   parameter int PHASE_W = 16,
   parameter int OUT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_mode,
   input  logic [PHASE_W-1:0] cfg_tune,
   input  logic [OUT_W-1:0]   cfg_duty,
   input  logic [OUT_W-1:0]   cfg_amp,
   output logic [OUT_W-1:0]   wave_out,
   output logic               wave_valid,
   output logic               wrap,
   output logic [1:0]         active_mode
);

   localparam int PW = 2 * OUT_W + 1;

   typedef struct packed {
      logic [1:0]         mode;
      logic [PHASE_W-1:0] tune;
      logic [OUT_W-1:0]   duty;
      logic [OUT_W-1:0]   amp;
   } cfg_t;

   localparam cfg_t CFG_RST = '{
      mode: 2'd0,
      tune: '0,
      duty: {1'b1, {(OUT_W-1){1'b0}}},
      amp:  '1
   };

   if (PHASE_W < OUT_W + 2) begin : g_bad_phase_w
      $error("wavegen_dds_core: PHASE_W must be at least OUT_W+2");
   end

   cfg_t               act_cfg;
   cfg_t               sh_cfg;
   logic               pending;
   logic [PHASE_W-1:0] phase;
   logic [OUT_W-1:0]   raw;
   logic [PW-1:0]      prod;
   logic [OUT_W-1:0]   scaled;

`ifdef WAVEGEN_SINE_LUT_EN
   if (OUT_W != 8) begin : g_bad_out_w
      $error("wavegen_dds_core: sine table needs OUT_W == 8");
   end

   // Quarter-wave table, Q[i] = round(127*sin(pi*(i+0.5)/128)).
   function automatic logic [6:0] sine_q(input logic [5:0] idx);
      logic [6:0] q;
      case (idx)
         6'd0:  q = 7'd2;
         6'd1:  q = 7'd5;
         6'd2:  q = 7'd8;
         6'd3:  q = 7'd11;
         6'd4:  q = 7'd14;
         6'd5:  q = 7'd17;
         6'd6:  q = 7'd20;
         6'd7:  q = 7'd23;
         6'd8:  q = 7'd26;
         6'd9:  q = 7'd29;
         6'd10: q = 7'd32;
         6'd11: q = 7'd35;
         6'd12: q = 7'd38;
         6'd13: q = 7'd41;
         6'd14: q = 7'd44;
         6'd15: q = 7'd47;
         6'd16: q = 7'd50;
         6'd17: q = 7'd53;
         6'd18: q = 7'd56;
         6'd19: q = 7'd58;
         6'd20: q = 7'd61;
         6'd21: q = 7'd64;
         6'd22: q = 7'd67;
         6'd23: q = 7'd69;
         6'd24: q = 7'd72;
         6'd25: q = 7'd74;
         6'd26: q = 7'd77;
         6'd27: q = 7'd79;
         6'd28: q = 7'd82;
         6'd29: q = 7'd84;
         6'd30: q = 7'd86;
         6'd31: q = 7'd89;
         6'd32: q = 7'd91;
         6'd33: q = 7'd93;
         6'd34: q = 7'd95;
         6'd35: q = 7'd97;
         6'd36: q = 7'd99;
         6'd37: q = 7'd101;
         6'd38: q = 7'd103;
         6'd39: q = 7'd105;
         6'd40: q = 7'd106;
         6'd41: q = 7'd108;
         6'd42: q = 7'd110;
         6'd43: q = 7'd111;
         6'd44: q = 7'd113;
         6'd45: q = 7'd114;
         6'd46: q = 7'd115;
         6'd47: q = 7'd117;
         6'd48: q = 7'd118;
         6'd49: q = 7'd119;
         6'd50: q = 7'd120;
         6'd51: q = 7'd121;
         6'd52: q = 7'd122;
         6'd53: q = 7'd123;
         6'd54: q = 7'd124;
         6'd55: q = 7'd124;
         6'd56: q = 7'd125;
         6'd57: q = 7'd125;
         6'd58: q = 7'd126;
         6'd59: q = 7'd126;
         default: q = 7'd127;
      endcase
      return q;
   endfunction

   logic [5:0] sine_idx;
   logic [6:0] sine_mag;
   logic [7:0] sine_raw;

   always_comb begin
      sine_idx = phase[PHASE_W-2] ? ~phase[PHASE_W-3 -: 6] : phase[PHASE_W-3 -: 6];
      sine_mag = sine_q(sine_idx);
      sine_raw = phase[PHASE_W-1] ? {1'b0, 7'd127 - sine_mag} : 8'd128 + {1'b0, sine_mag};
   end
`endif

   always_comb begin
      raw = '0;
      case (act_cfg.mode)
         2'd0: raw = (phase[PHASE_W-1 -: OUT_W] < act_cfg.duty) ? '1 : '0;
         2'd1: raw = phase[PHASE_W-1 -: OUT_W];
         2'd2: raw = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W];
`ifdef WAVEGEN_SINE_LUT_EN
         default: raw = OUT_W'(sine_raw);
`else
         default: raw = ~phase[PHASE_W-1 -: OUT_W];
`endif
      endcase
   end

   // amp+1 makes full-scale amplitude an exact pass-through
   always_comb begin
      prod   = PW'(raw) * (PW'(act_cfg.amp) + PW'(1));
      scaled = prod[OUT_W +: OUT_W];
   end

   assign cfg_ready   = !pending && !rst;
   assign active_mode = act_cfg.mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase      <= '0;
         wrap       <= 1'b0;
         act_cfg    <= CFG_RST;
         sh_cfg     <= '0;
         pending    <= 1'b0;
         wave_out   <= '0;
         wave_valid <= 1'b0;
      end else begin
         wave_valid <= en;
         wave_out   <= scaled;
         if (en) begin
            {wrap, phase} <= {1'b0, phase} + {1'b0, act_cfg.tune};
         end else begin
            wrap <= 1'b0;
         end
         // Commit waits for a phase wrap unless the accumulator is not moving.
         if (pending && (wrap || !en || act_cfg.tune == '0)) begin
            act_cfg <= sh_cfg;
            pending <= 1'b0;
         end else if (cfg_valid && cfg_ready) begin
            sh_cfg  <= '{mode: cfg_mode, tune: cfg_tune, duty: cfg_duty, amp: cfg_amp};
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wavegen_dds_core.sv
// Directed bench for wavegen_dds_core at PHASE_W=16, OUT_W=8: table-driven reset/config rows plus hand sequences.
module tb_wavegen_dds_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_tune;
   logic [7:0]  cfg_duty;
   logic [7:0]  cfg_amp;
   logic [7:0]  wave_out;
   logic        wave_valid;
   logic        wrap;
   logic [1:0]  active_mode;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wavegen_dds_core #(.PHASE_W(16), .OUT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mode   (cfg_mode),
      .cfg_tune   (cfg_tune),
      .cfg_duty   (cfg_duty),
      .cfg_amp    (cfg_amp),
      .wave_out   (wave_out),
      .wave_valid (wave_valid),
      .wrap       (wrap),
      .active_mode(active_mode)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        vld;
      logic [1:0]  mode;
      logic [15:0] tune;
      logic [7:0]  duty;
      logic [7:0]  amp;
      logic [7:0]  e_wave;
      logic        e_wvld;
      logic        e_wrap;
      logic        e_rdy;
      logic [1:0]  e_mode;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      cfg_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Load a config with the accumulator stopped, so it commits on the next cycle.
   task automatic load_cfg(input logic [1:0] m, input logic [15:0] t, input logic [7:0] d, input logic [7:0] a);
      chk("load_ready", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_mode = m;
      cfg_tune = t;
      cfg_duty = d;
      cfg_amp = a;
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("load_mode", active_mode, m);
      @(negedge clk);
   endtask

   initial begin
      int hi;
      int bad;
      int k;
      logic [7:0] e;

      rst = 1'b1;
      en = 1'b0;
      cfg_valid = 1'b0;
      cfg_mode = 2'd0;
      cfg_tune = 16'h0000;
      cfg_duty = 8'h80;
      cfg_amp = 8'hFF;

      //           rst   en    vld   mode  tune      duty   amp     wave   wvld  wrap  rdy   mode
      tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 2'd0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0100, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h0100, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd1, 16'h0100, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd1, 16'h0100, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 2'd1, 16'h0100, 8'h80, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 2'd1};

      for (int i = 0; i < 9; i++) begin
         rst = tbl[i].rst;
         en = tbl[i].en;
         cfg_valid = tbl[i].vld;
         cfg_mode = tbl[i].mode;
         cfg_tune = tbl[i].tune;
         cfg_duty = tbl[i].duty;
         cfg_amp = tbl[i].amp;
         @(negedge clk);
         chk("row_wave", wave_out, tbl[i].e_wave);
         chk("row_wvld", wave_valid, tbl[i].e_wvld);
         chk("row_wrap", wrap, tbl[i].e_wrap);
         chk("row_ready", cfg_ready, tbl[i].e_rdy);
         chk("row_mode", active_mode, tbl[i].e_mode);
      end

      // Saw running at one LSB per cycle; sample s comes from phase (s-1)*0x100.
      for (int s = 3; s <= 640; s++) begin
         @(negedge clk);
         chk("saw_wave", wave_out, (s - 1) & 255);
         chk("saw_wrap", wrap, (s % 256) == 0);
      end

      // Phase is 0x8000: offer a faster tune mid-period.
      cfg_valid = 1'b1;
      cfg_mode = 2'd1;
      cfg_tune = 16'h0200;
      cfg_duty = 8'h80;
      cfg_amp = 8'hFF;
      @(negedge clk);
      chk("mid_accept_ready", cfg_ready, 0);
      chk("mid_accept_wave", wave_out, 8'h80);
      cfg_valid = 1'b0;
      for (int s = 642; s <= 768; s++) begin
         @(negedge clk);
         chk("mid_wave", wave_out, (s - 1) & 255);
         chk("mid_ready", cfg_ready, 0);
         chk("mid_wrap", wrap, s == 768);
      end
      @(negedge clk);
      chk("commit_wave", wave_out, 8'h00);
      chk("commit_ready", cfg_ready, 1);
      chk("commit_wrap", wrap, 0);
      for (int s = 770; s <= 773; s++) begin
         @(negedge clk);
         chk("step2_wave", wave_out, 2 * (s - 770) + 1);
      end

      // en low: phase and output hold, strobes drop.
      en = 1'b0;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         chk("hold_wave", wave_out, 8'h09);
         chk("hold_wvld", wave_valid, 0);
         chk("hold_wrap", wrap, 0);
      end

      // Reset while a config is pending discards it.
      en = 1'b1;
      cfg_valid = 1'b1;
      cfg_mode = 2'd2;
      @(negedge clk);
      chk("discard_pending", cfg_ready, 0);
      cfg_valid = 1'b0;
      rst = 1'b1;
      en = 1'b0;
      @(negedge clk);
      chk("discard_rst_ready", cfg_ready, 0);
      chk("discard_rst_wave", wave_out, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("discard_ready", cfg_ready, 1);
      @(negedge clk);
      chk("discard_mode", active_mode, 0);

      // Square, 64-sample period, 16 high.
      do_reset();
      load_cfg(2'd0, 16'h0400, 8'h40, 8'hFF);
      en = 1'b1;
      hi = 0;
      for (int s = 1; s <= 128; s++) begin
         @(negedge clk);
         e = (((s - 1) % 64) < 16) ? 8'hFF : 8'h00;
         chk("sq_wave", wave_out, e);
         chk("sq_wrap", wrap, (s % 64) == 0);
         if (wave_out == 8'hFF) hi++;
      end
      chk("sq_high_count", hi, 32);

      // duty=0 never goes high.
      do_reset();
      load_cfg(2'd0, 16'h0400, 8'h00, 8'hFF);
      en = 1'b1;
      bad = 0;
      for (int s = 1; s <= 64; s++) begin
         @(negedge clk);
         if (wave_out != 8'h00) bad++;
      end
      chk("duty0_nonzero", bad, 0);

      // Running with zero tune commits immediately; half amplitude.
      do_reset();
      en = 1'b1;
      cfg_valid = 1'b1;
      cfg_mode = 2'd1;
      cfg_tune = 16'h0100;
      cfg_duty = 8'h80;
      cfg_amp = 8'h7F;
      @(negedge clk);
      chk("tune0_ready", cfg_ready, 0);
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("tune0_mode", active_mode, 1);
      for (int s = 1; s <= 256; s++) begin
         @(negedge clk);
         chk("amp_wave", wave_out, (s - 1) >> 1);
         if (s == 129) chk("amp_raw80", wave_out, 8'h40);
         if (s == 255) chk("amp_rawfe", wave_out, 8'h7F);
      end

      // Triangle.
      do_reset();
      load_cfg(2'd2, 16'h0100, 8'h80, 8'hFF);
      en = 1'b1;
      for (int s = 1; s <= 512; s++) begin
         @(negedge clk);
         k = (s - 1) % 256;
         chk("tri_wave", wave_out, (k < 128) ? 2 * k : 255 - 2 * (k - 128));
      end

`ifdef WAVEGEN_SINE_LUT_EN
      do_reset();
      load_cfg(2'd3, 16'h4000, 8'h80, 8'hFF);
      en = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         @(negedge clk);
         case ((s - 1) % 4)
            0: e = 8'd130;
            1: e = 8'd255;
            2: e = 8'd125;
            default: e = 8'd0;
         endcase
         chk("sine_wave", wave_out, e);
      end
`else
      do_reset();
      load_cfg(2'd3, 16'h0100, 8'h80, 8'hFF);
      en = 1'b1;
      for (int s = 1; s <= 256; s++) begin
         @(negedge clk);
         chk("rampdn_wave", wave_out, 255 - (s - 1));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
